// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: pops IN_WIDTH words from a registered-output sync FIFO
// and re-serialises each one onto a valid/ready stream as OUT_WIDTH chunks,
// most significant chunk first, so the first byte packed is the first byte out.
// Only one FIFO read is ever outstanding, which keeps the FIFO's lagging
// registered empty flag from ever causing an over-read.
module fifo_word_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CHUNKS = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WAIT,
    SHIFT
  } state_t;

  state_t               state_q, state_d;
  logic                 rd_en_q, rd_en_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]  shifted;
  logic                 handshake;

  // Next-state and registered-output logic: fetch a word, wait for the FIFO's
  // one-cycle read latency, then walk the chunks out MSB first on handshakes.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    shifted   = shreg_q << OUT_WIDTH;
    handshake = valid_q && out_ready;

    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        state_d = WAIT;
      end
      WAIT: begin
        shreg_d = fifo_dout;
        data_d  = fifo_dout[IN_WIDTH-1 -: OUT_WIDTH];
        valid_d = 1'b1;
        cnt_d   = '0;
        last_d  = (CHUNKS == 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        if (handshake) begin
          if (cnt_q != LAST_CNT) begin
            shreg_d = shifted;
            data_d  = shifted[IN_WIDTH-1 -: OUT_WIDTH];
            cnt_d   = cnt_q + CNT_W'(1);
            last_d  = ((cnt_q + CNT_W'(1)) == LAST_CNT);
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (en && !fifo_empty) begin
              rd_en_d = 1'b1;
              state_d = RD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign out_data   = data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Self-checking bench for fifo_word_unpacker: a behavioural FIFO feeds the
// DUT, and a scoreboard expects every pushed word back as MSB-first bytes.
module tb_fifo_word_unpacker;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } chunk_t;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  exp_bytes [4];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        out_ready = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        busy;

  logic        f16_empty = 1'b1;
  logic [15:0] f16_dout = '0;
  logic        f16_rd_en;
  logic [15:0] o16_data;
  logic        o16_valid;
  logic        o16_last;
  logic        busy16;
  logic        en16 = 1'b0;
  logic        ready16 = 1'b1;

  logic [31:0] fifo_q [$];
  logic [15:0] f16_q [$];
  chunk_t      exp_q [$];
  logic [15:0] exp16_q [$];
  logic [7:0]  rx_q [$];

  int errors = 0;
  int checks = 0;
  int rd_pulse_cnt = 0;
  int hs_cnt = 0;
  int gap_cnt = 0;
  int hs16_cnt = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic       prev_rd = 1'b0;

  vec_t table_v [4];

  always #5 clk = ~clk;

  fifo_word_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  fifo_word_unpacker #(.IN_WIDTH(16), .OUT_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .fifo_empty(f16_empty),
    .fifo_rd_en(f16_rd_en), .fifo_dout(f16_dout), .out_data(o16_data),
    .out_valid(o16_valid), .out_ready(ready16), .out_last(o16_last),
    .busy(busy16)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en_v, input logic rdy_v, input int n);
    en = en_v;
    out_ready = rdy_v;
    stepCycles(n);
  endtask

  // Reference model: a word leaves as its bytes, most significant first.
  task automatic pushWord(input logic [31:0] w);
    chunk_t c;
    fifo_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      c.data = w[31 - 8*i -: 8];
      c.last = (i == 3);
      exp_q.push_back(c);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    fifo_q.delete();
    f16_q.delete();
    exp_q.delete();
    exp16_q.delete();
    rx_q.delete();
    stepCycles(2);
    rd_pulse_cnt = 0;
    hs_cnt = 0;
    gap_cnt = 0;
    hs16_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic waitRx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      stepCycles(1);
      k++;
    end
    if (rx_q.size() < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: timeout, got %0d chunks, expected %0d", name, rx_q.size(), n);
    end
  endtask

  // Behavioural FIFOs with registered empty and one-cycle read latency.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
    if (f16_rd_en && f16_q.size() > 0) f16_dout <= f16_q.pop_front();
    f16_empty <= (f16_q.size() == 0);
  end

  // Stream monitor: scoreboard, stall stability, read-pulse and over-read checks.
  always @(negedge clk) begin
    chunk_t e;
    if (rst) begin
      prev_stall = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("stall_data", {24'b0, out_data}, {24'b0, prev_data});
        checkOutput("stall_last", {31'b0, out_last}, {31'b0, prev_last});
      end
      if (fifo_rd_en) begin
        rd_pulse_cnt++;
        checkOutput("rd_single_pulse", {31'b0, prev_rd}, 32'd0);
        checkOutput("overread_guard", {31'b0, fifo_q.size() > 0}, 32'd1);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        rx_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_chunk: got %0h, expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("chunk_data", {24'b0, out_data}, {24'b0, e.data});
          checkOutput("chunk_last", {31'b0, out_last}, {31'b0, e.last});
        end
      end else if (!out_valid && hs_cnt > 0) begin
        gap_cnt++;
      end
      if (o16_valid && ready16) begin
        hs16_cnt++;
        if (exp16_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word16: got %0h, expected none", o16_data);
        end else begin
          checkOutput("w16_data", {16'b0, o16_data}, {16'b0, exp16_q.pop_front()});
          checkOutput("w16_last", {31'b0, o16_last}, 32'd1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      prev_rd = fifo_rd_en;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       pat [7];
    logic [7:0] stall_exp [6];
    logic [15:0] w16;
    int         pushed;
    int         k;

    table_v[0].word = 32'hA1B2C3D4; table_v[0].exp_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    table_v[1].word = 32'h00000000; table_v[1].exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    table_v[2].word = 32'hFFFFFFFF; table_v[2].exp_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    table_v[3].word = 32'h80FF0102; table_v[3].exp_bytes = '{8'h80, 8'hFF, 8'h01, 8'h02};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    stall_exp = '{8'hAD, 8'hAD, 8'hAD, 8'hBE, 8'hBE, 8'hEF};

    // Reset state
    applyReset();
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_last", {31'b0, out_last}, 32'd0);
    checkOutput("rst_data", {24'b0, out_data}, 32'd0);
    checkOutput("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);

    // Latency and ordering of a single word
    en = 1'b1;
    out_ready = 1'b1;
    pushWord(32'hA1B2C3D4);
    stepCycles(1);
    checkOutput("lat_c1_rd", {31'b0, fifo_rd_en}, 32'd0);
    stepCycles(1);
    checkOutput("lat_c2_rd", {31'b0, fifo_rd_en}, 32'd1);
    checkOutput("lat_c2_busy", {31'b0, busy}, 32'd1);
    stepCycles(1);
    checkOutput("lat_c3_rd", {31'b0, fifo_rd_en}, 32'd0);
    checkOutput("lat_c3_valid", {31'b0, out_valid}, 32'd0);
    stepCycles(1);
    checkOutput("lat_c4_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("lat_b0", {24'b0, out_data}, 32'hA1);
    checkOutput("lat_l0", {31'b0, out_last}, 32'd0);
    stepCycles(1);
    checkOutput("lat_b1", {24'b0, out_data}, 32'hB2);
    checkOutput("lat_l1", {31'b0, out_last}, 32'd0);
    stepCycles(1);
    checkOutput("lat_b2", {24'b0, out_data}, 32'hC3);
    checkOutput("lat_l2", {31'b0, out_last}, 32'd0);
    stepCycles(1);
    checkOutput("lat_b3", {24'b0, out_data}, 32'hD4);
    checkOutput("lat_l3", {31'b0, out_last}, 32'd1);
    stepCycles(1);
    checkOutput("lat_end_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("lat_end_busy", {31'b0, busy}, 32'd0);
    stepCycles(3);
    checkOutput("lat_rd_pulses", rd_pulse_cnt, 32'd1);

    // Back-to-back words
    applyReset();
    pushWord(32'h01020304);
    pushWord(32'h05060708);
    applyStimulus(1'b1, 1'b1, 1);
    waitRx(8, 60, "b2b_wait");
    checkOutput("b2b_gap", gap_cnt, 32'd2);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      checkOutput("b2b_byte", {24'b0, rx_q[i]}, i + 1);
    stepCycles(4);
    checkOutput("b2b_rd_pulses", rd_pulse_cnt, 32'd2);
    checkOutput("b2b_busy", {31'b0, busy}, 32'd0);

    // Table-driven words
    for (int v = 0; v < 4; v++) begin
      rx_q.delete();
      pushWord(table_v[v].word);
      waitRx(4, 40, "tbl_wait");
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
        checkOutput("tbl_byte", {24'b0, rx_q[i]}, {24'b0, table_v[v].exp_bytes[i]});
      stepCycles(2);
      checkOutput("tbl_idle", {31'b0, busy}, 32'd0);
    end

    // Backpressure pattern
    rx_q.delete();
    out_ready = 1'b0;
    pushWord(32'hDEADBEEF);
    k = 0;
    while (!out_valid && k < 20) begin
      stepCycles(1);
      k++;
    end
    checkOutput("bp_valid_up", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_first", {24'b0, out_data}, 32'hDE);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      stepCycles(1);
      if (i < 6) checkOutput("bp_hold", {24'b0, out_data}, {24'b0, stall_exp[i]});
    end
    out_ready = 1'b0;
    stepCycles(2);
    checkOutput("bp_count", rx_q.size(), 32'd4);
    if (rx_q.size() == 4) begin
      checkOutput("bp_b0", {24'b0, rx_q[0]}, 32'hDE);
      checkOutput("bp_b1", {24'b0, rx_q[1]}, 32'hAD);
      checkOutput("bp_b2", {24'b0, rx_q[2]}, 32'hBE);
      checkOutput("bp_b3", {24'b0, rx_q[3]}, 32'hEF);
    end
    checkOutput("bp_idle", {31'b0, busy}, 32'd0);

    // Start permission
    applyReset();
    pushWord(32'h11223344);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("en0_no_read", rd_pulse_cnt, 32'd0);
    checkOutput("en0_busy", {31'b0, busy}, 32'd0);
    pushWord(32'h55667788);
    en = 1'b1;
    waitRx(1, 20, "en_first");
    en = 1'b0;
    waitRx(4, 20, "en_rest");
    stepCycles(12);
    checkOutput("en_drop_busy", {31'b0, busy}, 32'd0);
    checkOutput("en_drop_reads", rd_pulse_cnt, 32'd1);
    checkOutput("en_drop_count", rx_q.size(), 32'd4);
    if (rx_q.size() == 4) checkOutput("en_drop_last", {24'b0, rx_q[3]}, 32'h44);

    // Reset in the middle of a word
    applyReset();
    pushWord(32'hCAFEF00D);
    applyStimulus(1'b1, 1'b1, 1);
    waitRx(2, 20, "mid_wait");
    out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    stepCycles(1);
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("mid_rst_data", {24'b0, out_data}, 32'd0);
    rst = 1'b0;
    rd_pulse_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stepCycles(1);
      checkOutput("post_rst_quiet", {30'b0, out_valid, busy}, 32'd0);
    end
    checkOutput("post_rst_reads", rd_pulse_cnt, 32'd0);

    // Single-chunk pass-through configuration
    for (int i = 0; i < 3; i++) begin
      w16 = 16'(32'h1234 + 32'h1111 * i);
      f16_q.push_back(w16);
      exp16_q.push_back(w16);
    end
    en16 = 1'b1;
    k = 0;
    while (hs16_cnt < 3 && k < 60) begin
      stepCycles(1);
      k++;
    end
    checkOutput("w16_count", hs16_cnt, 32'd3);
    en16 = 1'b0;

    // Randomized traffic against the reference model
    applyReset();
    pushed = 0;
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (pushed < 40 && $urandom_range(0, 4) == 0) begin
        pushWord($urandom);
        pushed++;
      end
      stepCycles(1);
    end
    en = 1'b1;
    out_ready = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 400) begin
      stepCycles(1);
      k++;
    end
    checkOutput("rand_drained", exp_q.size(), 32'd0);
    checkOutput("rand_fifo_empty", fifo_q.size(), 32'd0);
    checkOutput("rand_idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
